interval_timer_arbiter: RTL
===========================

INTERVAL_TIMER_ARBITER -- requirements
Module: interval_timer_arbiter

Interface
REQ-001 Parameter: BIT_SZ, default 10, width of the shared interval counter and of both duration inputs.
REQ-002 Port: clock  input  1  single clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: tick  input  1  count-enable strobe; the shared counter advances only on RUN cycles with tick=1.
REQ-005 Port: req0, req1  input  1 each  requester timer requests, level-held until done or abort.
REQ-006 Port: dur0, dur1  input  BIT_SZ each  requested interval in ticks, sampled only at grant.
REQ-007 Port: gnt0, gnt1  output  1 each  registered grant, one-hot or zero.
REQ-008 Port: done0, done1  output  1 each  registered one-cycle completion pulse.
REQ-009 Port: busy  output  1  high while state is RUN or DONE.
REQ-010 Port: count  output  BIT_SZ  ticks elapsed in the current or most recent interval.

Function
REQ-011 The block SHALL implement three states, IDLE, RUN and DONE, with all outputs driven from registers.
REQ-012 IDLE: if any reqN=1 at an edge, the block SHALL grant exactly one requester, latch term=durN, clear count to 0, set gntN=1 and enter RUN.
REQ-013 Arbitration SHALL be round-robin on a last-served pointer: if both request, the requester not served last wins; with a single request, that requester wins.
REQ-014 The last-served pointer SHALL update only on a grant, never on abort.
REQ-015 RUN: on each edge with tick=1, the block SHALL increment count by 1, modulo 2^BIT_SZ; tick=0 holds count.
REQ-016 RUN completion: on an edge with tick=1 and count==term-1 (mod 2^BIT_SZ), the block SHALL set count=count+1, clear gnt, pulse the matching doneN=1 and enter DONE.
REQ-017 Duration 0 SHALL mean 2^BIT_SZ ticks, which falls out of REQ-016; count then reads 0 after completion.
REQ-018 Abort: in RUN, if the granted reqN is 0 at an edge, the block SHALL clear gnt, enter IDLE, hold count and produce no done; abort takes precedence over simultaneous completion.
REQ-019 DONE SHALL last exactly one cycle, perform no arbitration and return unconditionally to IDLE, clearing doneN.
REQ-020 A requester SHALL deassert req in the DONE cycle; a req still high in IDLE is treated as a new request.
REQ-021 Latency SHALL be as follows: grant 1 edge after req is seen in IDLE; done d edges after the grant for d ticks; minimum 2 cycles from done to the next grant.
REQ-022 tick, dur and the non-granted req SHALL be ignored outside their defined uses; count SHALL hold its value in IDLE and DONE.
REQ-023 At most one of gnt0/gnt1 and at most one of done0/done1 SHALL ever be high, and gnt and done SHALL never be high in the same cycle.

Reset
REQ-024 While reset=1, asynchronously and regardless of clock, the block SHALL force state=IDLE, gnt0=gnt1=0, done0=done1=0, busy=0, count=0, term=0 and the pointer to "req1 served last" (req0 wins the first tie).
REQ-025 Reset asserted mid-RUN SHALL abandon the interval without any done pulse.
REQ-026 After reset release, the first grant SHALL occur no earlier than the first rising edge with reset=0.

Verification
REQ-027 Single request: req0=1, dur0=3, tick=1 constant -> gnt0 high 3 cycles, count 0,1,2, then done0 pulse with count=3, busy low 1 cycle later.
REQ-028 Tie and fairness: req0=req1=1 from reset, dur=2 each, both dropping req on their done -> grant order 0,1,0,1, never the same requester twice while the other waits.
REQ-029 Tick gating: dur1=4, tick toggling 1,0,1,0 -> count advances only on tick=1, done1 after 4 ticks (8 cycles after grant).
REQ-030 Wrap: BIT_SZ=10, dur0=0 -> done0 after exactly 1024 ticks, count reads 0 after completion.
REQ-031 Abort: req0 dropped at count=5 of dur0=10, including the case where the drop coincides with the final tick -> gnt0 falls, no done0, next grant goes to the pending req1.
REQ-032 Reset mid-RUN: assert reset between clock edges at count=7 -> outputs go to reset values immediately; after release with req0=req1=1, req0 is granted.

Source files
------------

// File: rtl/interval_timer_arbiter.sv
// Two-requester interval timer. One shared counter is granted round-robin
// to req0/req1 and counts the granted duration in tick strobes. Every output
// comes straight from a register.
module interval_timer_arbiter #(
    parameter int BIT_SZ = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tick,
    input  logic              req0,
    input  logic              req1,
    input  logic [BIT_SZ-1:0] dur0,
    input  logic [BIT_SZ-1:0] dur1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              busy,
    output logic [BIT_SZ-1:0] count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [BIT_SZ-1:0] ONE = BIT_SZ'(1);

    state_t            state_q, state_d;
    logic [BIT_SZ-1:0] count_q, count_d;
    logic [BIT_SZ-1:0] term_q, term_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic              last_q, last_d;   // 1: req1 was served last
    logic              busy_q, busy_d;

    logic              pick;             // 1: req1 wins the arbitration
    logic              greq;             // request line of the current owner
    logic              at_term;

    // req1 wins when it is alone, or when both request and req0 went last.
    assign pick    = req1 & (~req0 | ~last_q);
    assign greq    = gnt_q[1] ? req1 : req0;
    // term==0 gives term-1 == all ones, so a zero duration runs 2^BIT_SZ ticks.
    assign at_term = (count_q == (term_q - ONE));

    // Next-state logic: arbitration in IDLE, counting/abort in RUN, one-cycle DONE.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        term_d  = term_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    state_d = RUN;
                    term_d  = pick ? dur1 : dur0;
                    count_d = '0;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    last_d  = pick;
                end
            end
            RUN: begin
                // Abort is checked first so it beats a coincident final tick.
                if (!greq) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else if (tick) begin
                    count_d = count_q + ONE;
                    if (at_term) begin
                        state_d = DONE;
                        gnt_d   = '0;
                        done_d  = gnt_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State register; reset leaves the pointer at "req1 last" so req0 wins the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            term_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            last_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            term_q  <= term_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt0  = gnt_q[0];
    assign gnt1  = gnt_q[1];
    assign done0 = done_q[0];
    assign done1 = done_q[1];
    assign busy  = busy_q;
    assign count = count_q;

endmodule
